// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 byte-level write driver: power-on init, EN timing and
// execution waits behind a valid/ready byte interface.
module lcd_hd44780_ctrl #(
  parameter bit INIT_EN       = 1'b1,
  parameter int T_POWERON_CYC = 750000,
  parameter int T_SETUP_CYC   = 4,
  parameter int T_EN_CYC      = 25,
  parameter int T_HOLD_CYC    = 2,
  parameter int T_EXEC_CYC    = 2500,
  parameter int T_CLR_CYC     = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(
    max2(max2(T_POWERON_CYC, T_SETUP_CYC),
         max2(T_EN_CYC, T_HOLD_CYC)),
    max2(T_EXEC_CYC, T_CLR_CYC));
  localparam int CW = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] L_PON   = CW'(T_POWERON_CYC - 1);
  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] L_EN    = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] L_EXEC  = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] L_CLR   = CW'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          in_init;
  logic          cnt_zero;
  logic          long_wait;

  function automatic logic [7:0] rom(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h06;
      default:          return 8'h01;
    endcase
  endfunction

  assign cnt_zero = (cnt == '0);
  // clear-display and return-home need the long execution wait
  assign long_wait = !o_lcd_rs
                   && (o_lcd_data[7:2] == 6'd0)
                   && (o_lcd_data[1:0] != 2'd0);
  assign o_lcd_rw = 1'b0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= INIT_EN ? S_INIT_WAIT : S_IDLE;
      cnt         <= L_PON;
      idx         <= 3'd0;
      in_init     <= INIT_EN;
      o_ready     <= 1'b0;
      o_init_done <= 1'b0;
      o_lcd_on    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_data  <= 8'h00;
    end else begin
      o_lcd_on <= 1'b1;
      if (!INIT_EN) o_init_done <= 1'b1;
      unique case (state)
        S_INIT_WAIT: begin
          if (cnt_zero) begin
            state      <= S_SETUP;
            cnt        <= L_SETUP;
            idx        <= 3'd0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= rom(3'd0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (o_ready && i_valid) begin
            o_ready    <= 1'b0;
            o_lcd_rs   <= i_rs;
            o_lcd_data <= i_data;
            cnt        <= L_SETUP;
            state      <= S_SETUP;
          end else begin
            o_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            o_lcd_en <= 1'b1;
            cnt      <= L_EN;
            state    <= S_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            o_lcd_en <= 1'b0;
            cnt      <= L_HOLD;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            cnt   <= long_wait ? L_CLR : L_EXEC;
            state <= S_EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_EXEC: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (in_init && idx != 3'd5) begin
            idx        <= idx + 3'd1;
            o_lcd_data <= rom(idx + 3'd1);
            cnt        <= L_SETUP;
            state      <= S_SETUP;
          end else begin
            if (in_init) begin
              in_init     <= 1'b0;
              o_init_done <= 1'b1;
            end
            o_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
